// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register.
// Contents: operation codes on the mode input, bit-cell mux selects and the
// burst sequencer's state encoding.
package shift_pkg;

  // Operation codes on the mode input
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Bit-cell next-value select. "left" is the more-significant neighbour
  // (used by right shifts), "right" the less-significant one.
  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_LEFT  = 2'd1;
  localparam logic [1:0] SEL_RIGHT = 2'd2;
  localparam logic [1:0] SEL_LOAD  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 next-value mux feeding an
// asynchronously reset flop, plus a registered complement.
// Ports:
//   clk, rst  clock (rising edge) and async active-high reset
//   sel       next-value select (hold / left nbr / right nbr / load)
//   left_in   value of the more-significant neighbour (or serial/rotate in)
//   right_in  value of the less-significant neighbour (or serial/rotate in)
//   load_in   parallel load value
//   q, q_bar  stored bit and its registered complement
module usr_bit_cell
  import shift_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       load_in,
  output logic       q,
  output logic       q_bar
);

  logic nxt;

  always_comb begin
    nxt = q;
    unique case (sel)
      SEL_HOLD:  nxt = q;
      SEL_LEFT:  nxt = left_in;
      SEL_RIGHT: nxt = right_in;
      SEL_LOAD:  nxt = load_in;
      default:   nxt = q;
    endcase
  end

  // q_bar is its own flop fed from ~nxt so it switches on the same edge as q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= RST_BIT;
      q_bar <= ~RST_BIT;
    end else begin
      q     <= nxt;
      q_bar <= ~nxt;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: WIDTH bits with hold / shift / rotate / load / clear per
// cycle, plus a burst sequencer that shifts right N times after a start pulse.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   en, mode        single-step operation enable and select (ignored while busy)
//   d               parallel load data
//   sin_l, sin_r    serial inputs at MSB (right shifts) and LSB (left shift)
//   start, nshift   burst request and length, sampled only when idle
//   q, q_bar        register contents and registered complement
//   sout_r, sout_l  q[0] and q[WIDTH-1]
//   busy, done      burst in progress; one-cycle pulse after the last shift
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0,
  parameter int unsigned           CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_start;

  // Decoded single-step operation (applied only when the FSM allows it)
  logic [1:0] op_sel;
  logic       op_msb, op_lsb, op_clr;

  // Final controls shared by all bit cells
  logic [1:0]       sel;
  logic             msb_in, lsb_in, clr;
  logic [WIDTH-1:0] load_val;

  assign cnt_start = (nshift > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : nshift;

  always_comb begin
    op_sel = SEL_HOLD;
    op_msb = sin_l;
    op_lsb = sin_r;
    op_clr = 1'b0;
    unique case (mode)
      MODE_SHR:  op_sel = SEL_LEFT;
      MODE_SHL:  op_sel = SEL_RIGHT;
      MODE_ROR: begin
        op_sel = SEL_LEFT;
        op_msb = q[0];
      end
      MODE_ROL: begin
        op_sel = SEL_RIGHT;
        op_lsb = q[WIDTH-1];
      end
      MODE_LOAD: op_sel = SEL_LOAD;
      MODE_CLR: begin
        op_sel = SEL_LOAD;
        op_clr = 1'b1;
      end
      default:   op_sel = SEL_HOLD;  // MODE_HOLD and MODE_RSVD
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = SEL_HOLD;
    msb_in  = sin_l;
    lsb_in  = sin_r;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start wins over any single-step op requested in the same cycle
        if (start) begin
          cnt_d   = cnt_start;
          state_d = (cnt_start == '0) ? StDone : StShift;
        end else if (en) begin
          sel    = op_sel;
          msb_in = op_msb;
          lsb_in = op_lsb;
          clr    = op_clr;
        end
      end
      StShift: begin
        sel    = SEL_LEFT;
        msb_in = sin_l;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Single-step ops are honoured here; start is not
        state_d = StIdle;
        if (en) begin
          sel    = op_sel;
          msb_in = op_msb;
          lsb_in = op_lsb;
          clr    = op_clr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_val = clr ? '0 : d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic left_in, right_in;

    if (i == WIDTH - 1) begin : g_msb
      assign left_in = msb_in;
    end else begin : g_mid_l
      assign left_in = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign right_in = lsb_in;
    end else begin : g_mid_r
      assign right_in = q[i-1];
    end

    usr_bit_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .left_in  (left_in),
      .right_in (right_in),
      .load_in  (load_val[i]),
      .q        (q[i]),
      .q_bar    (q_bar[i])
    );
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
module tb_univ_shift_reg;
  import shift_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l, sin_r, start;
  logic [3:0] nshift;
  logic [7:0] q, q_bar;
  logic       sout_r, sout_l, busy, done;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic       st;
    logic [3:0] ns;
  } stim_t;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  univ_shift_reg #(
    .WIDTH   (8),
    .RST_VAL (8'h00),
    .CNT_W   (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .nshift (nshift),
    .q      (q),
    .q_bar  (q_bar),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic e, logic [2:0] m, logic [7:0] dd, logic sl, logic sr,
                               logic st, logic [3:0] ns);
    stim_t s;
    s.en = e; s.mode = m; s.d = dd; s.sl = sl; s.sr = sr; s.st = st; s.ns = ns;
    return s;
  endfunction

  function automatic exp_t ex(logic [7:0] eq, logic eb, logic ed);
    exp_t x;
    x.q = eq; x.busy = eb; x.done = ed;
    return x;
  endfunction

  task automatic apply(stim_t s);
    en = s.en; mode = s.mode; d = s.d; sin_l = s.sl; sin_r = s.sr;
    start = s.st; nshift = s.ns;
  endtask

  stim_t idle_s;

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    apply(idle_s);
    sb.push_back(ex(8'h00, 1'b0, 1'b0));
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (q !== e.q || q_bar !== ~e.q || busy !== e.busy || done !== e.done) begin
      n_errors++;
      $display("FAIL reset_init: got q=%h q_bar=%h busy=%b done=%b, want q=%h q_bar=%h busy=%b done=%b",
               q, q_bar, busy, done, e.q, ~e.q, e.busy, e.done);
    end
    rst = 1'b0;
    apply(mk(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0));
    sb.push_back(ex(8'hA5, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (q !== e.q || q_bar !== ~e.q || busy !== e.busy || done !== e.done || sout_l !== e.q[7]
        || sout_r !== e.q[0]) begin
      n_errors++;
      $display("FAIL reset_load: got q=%h q_bar=%h busy=%b done=%b, want q=%h q_bar=%h busy=%b done=%b",
               q, q_bar, busy, done, e.q, ~e.q, e.busy, e.done);
    end
    // Mid-cycle asynchronous reset must clear without waiting for an edge
    #2 rst = 1'b1;
    sb.push_back(ex(8'h00, 1'b0, 1'b0));
    #1;
    e = sb.pop_front();
    n_checks++;
    if (q !== e.q || q_bar !== ~e.q || busy !== e.busy || done !== e.done) begin
      n_errors++;
      $display("FAIL reset_async: got q=%h q_bar=%h busy=%b done=%b, want q=%h q_bar=%h busy=%b done=%b",
               q, q_bar, busy, done, e.q, ~e.q, e.busy, e.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs a stimulus/expectation table one cycle per entry
  task automatic run_table(string name, stim_t s[], exp_t x[]);
    exp_t e;
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q || q_bar !== ~e.q || busy !== e.busy || done !== e.done
          || sout_l !== e.q[7] || sout_r !== e.q[0]) begin
        n_errors++;
        $display("FAIL %s[%0d]: got q=%h q_bar=%h busy=%b done=%b, want q=%h q_bar=%h busy=%b done=%b",
                 name, i, q, q_bar, busy, done, e.q, ~e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_ops();
    stim_t s[];
    exp_t  x[];
    s = new[6];
    x = new[6];
    s[0] = mk(1'b1, MODE_LOAD, 8'hB4, 1'b0, 1'b0, 1'b0, 4'd0); x[0] = ex(8'hB4, 1'b0, 1'b0);
    s[1] = mk(1'b1, MODE_SHR,  8'h00, 1'b1, 1'b0, 1'b0, 4'd0); x[1] = ex(8'hDA, 1'b0, 1'b0);
    s[2] = mk(1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0, 1'b0, 4'd0); x[2] = ex(8'hB4, 1'b0, 1'b0);
    s[3] = mk(1'b1, MODE_ROR,  8'h00, 1'b1, 1'b1, 1'b0, 4'd0); x[3] = ex(8'h5A, 1'b0, 1'b0);
    s[4] = mk(1'b1, MODE_ROL,  8'h00, 1'b1, 1'b1, 1'b0, 4'd0); x[4] = ex(8'hB4, 1'b0, 1'b0);
    s[5] = mk(1'b1, MODE_RSVD, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0); x[5] = ex(8'hB4, 1'b0, 1'b0);
    run_table("ops", s, x);
  endtask

  task automatic test_enable();
    stim_t s[];
    exp_t  x[];
    s = new[5];
    x = new[5];
    s[0] = mk(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0); x[0] = ex(8'h81, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      s[i] = mk(1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0);
      x[i] = ex(8'h81, 1'b0, 1'b0);
    end
    s[4] = mk(1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0); x[4] = ex(8'h00, 1'b0, 1'b0);
    run_table("enable", s, x);
  endtask

  task automatic test_burst();
    stim_t s[];
    exp_t  x[];
    s = new[6];
    x = new[6];
    s[0] = mk(1'b1, MODE_LOAD, 8'hF0, 1'b0, 1'b0, 1'b0, 4'd0); x[0] = ex(8'hF0, 1'b0, 1'b0);
    // start competes with a LOAD of 00; start must win and q must not change
    s[1] = mk(1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3); x[1] = ex(8'hF0, 1'b1, 1'b0);
    s[2] = mk(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0); x[2] = ex(8'h78, 1'b1, 1'b0);
    s[3] = s[2];                                               x[3] = ex(8'h3C, 1'b1, 1'b0);
    s[4] = s[2];                                               x[4] = ex(8'h1E, 1'b0, 1'b1);
    s[5] = s[2];                                               x[5] = ex(8'h1E, 1'b0, 1'b0);
    run_table("burst3", s, x);
  endtask

  task automatic test_back_to_back();
    stim_t      s[];
    exp_t       x[];
    logic [7:0] m;
    s = new[13];
    x = new[13];
    // nshift=0: done next cycle, q unchanged; single-step honoured in the DONE cycle
    s[0] = mk(1'b0, MODE_HOLD, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0); x[0] = ex(8'h1E, 1'b0, 1'b1);
    s[1] = mk(1'b1, MODE_SHL,  8'h00, 1'b0, 1'b1, 1'b0, 4'd0); x[1] = ex(8'h3D, 1'b0, 1'b0);
    // nshift=15 clamps to 8 shifts of sin_l=1
    s[2] = mk(1'b0, MODE_HOLD, 8'h00, 1'b1, 1'b0, 1'b1, 4'd15); x[2] = ex(8'h3D, 1'b1, 1'b0);
    m = 8'h3D;
    for (int k = 1; k <= 8; k++) begin
      m = {1'b1, m[7:1]};
      // start and a CLR while busy must both be ignored
      s[2+k] = mk(k == 2, MODE_CLR, 8'h00, 1'b1, 1'b0, k == 2, 4'd1);
      x[2+k] = ex(m, k < 8, k == 8);
    end
    // start during DONE is ignored: return to idle, not a new burst
    s[11] = mk(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2); x[11] = ex(8'hFF, 1'b0, 1'b0);
    s[12] = mk(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0); x[12] = ex(8'hFF, 1'b0, 1'b0);
    run_table("burst_edge", s, x);
  endtask

  task automatic test_reset_mid_burst();
    stim_t s[];
    exp_t  x[];
    exp_t  e;
    s = new[4];
    x = new[4];
    s[0] = mk(1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0); x[0] = ex(8'h5A, 1'b0, 1'b0);
    s[1] = mk(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4); x[1] = ex(8'h5A, 1'b1, 1'b0);
    s[2] = mk(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0); x[2] = ex(8'h2D, 1'b1, 1'b0);
    s[3] = s[2];                                               x[3] = ex(8'h16, 1'b1, 1'b0);
    run_table("pre_rst", s, x);
    #2 rst = 1'b1;
    sb.push_back(ex(8'h00, 1'b0, 1'b0));
    #1;
    e = sb.pop_front();
    n_checks++;
    if (q !== e.q || q_bar !== ~e.q || busy !== e.busy || done !== e.done) begin
      n_errors++;
      $display("FAIL rst_mid_burst: got q=%h q_bar=%h busy=%b done=%b, want q=%h q_bar=%h busy=%b done=%b",
               q, q_bar, busy, done, e.q, ~e.q, e.busy, e.done);
    end
    @(negedge clk);
    rst = 1'b0;
    s = new[3];
    x = new[3];
    for (int i = 0; i < 3; i++) begin
      s[i] = mk(1'b0, MODE_HOLD, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
      x[i] = ex(8'h00, 1'b0, 1'b0);
    end
    run_table("post_rst", s, x);
  endtask

  initial begin
    idle_s = mk(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    test_reset();
    test_ops();
    test_enable();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
